// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - md_state_e       : mult/div busy FSM encoding (RUN = 0, MD_WAIT = 1)
//   - MUL_LAT_DEFAULT  : default multiply hold latency in cycles
//   - DIV_LAT_DEFAULT  : default divide hold latency in cycles
//   - lat_load_value() : converts a latency into the down-counter load value
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    localparam int unsigned MUL_LAT_DEFAULT = 4;
    localparam int unsigned DIV_LAT_DEFAULT = 32;

    // The issue cycle is spent in RUN, so the counter only has to cover the
    // remaining LAT-1 cycles spent in MD_WAIT before md_done.
    function automatic int unsigned lat_load_value(input int unsigned lat);
        return lat - 1;
    endfunction

endpackage

// File: rtl/md_latency_cnt.sv
// -----------------------------------------------------------------------------
// md_latency_cnt
// Loadable down-counter used to time multi-cycle execute units.
// Ports:
//   clk        in   pipeline clock
//   rst_n      in   asynchronous active-low reset (count clears to 0)
//   load_i     in   load load_val_i (takes precedence over dec_i)
//   load_val_i in   value to load
//   dec_i      in   decrement by one; ignored when already zero
//   cnt_o      out  current count
//   zero_o     out  count is zero
// -----------------------------------------------------------------------------
module md_latency_cnt #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Merges data-memory
// wait, the mult/div hold, the ID hazard stall and branch/jump redirects into
// per-stage register enables and flushes, in that priority order. Owns the
// mult/div busy FSM and a saturating stall-cycle counter.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   hz_stall                   hazard unit: hold PC and IF/ID, bubble ID/EX
//   br_taken, jump             ID-stage redirect: flush IF/ID
//   md_start, md_is_div        mult/div instruction in EX, divide select
//   dmem_busy                  data memory not ready: freeze PC..EX/MEM
//   pc_en, ifid_en, idex_en, exmem_en                 stage load enables
//   ifid_flush, idex_flush, exmem_flush, memwb_flush  stage clears
//   md_busy                    FSM is in MD_WAIT
//   md_done                    one-cycle pulse: mult/div result valid in EX
//   stall_cycles               saturating count of cycles with pc_en = 0
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
    parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hz_stall,
    input  logic              br_taken,
    input  logic              jump,
    input  logic              md_start,
    input  logic              md_is_div,
    input  logic              dmem_busy,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(lat_load_value(MUL_LAT));
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(lat_load_value(DIV_LAT));

    md_state_e        state_q;
    md_state_e        state_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             md_hold;
    logic             md_done_int;

    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] stall_cycles_d;

    // ---------------------------------------------------------------------
    // Mult/div latency counter
    // ---------------------------------------------------------------------
    md_latency_cnt #(
        .CNT_W (CNT_W)
    ) u_md_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // ---------------------------------------------------------------------
    // Mult/div busy FSM. It advances even while dmem_busy freezes the
    // pipeline, because the arithmetic unit runs on its own.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = MUL_LOAD;
        cnt_dec      = 1'b0;
        md_hold      = 1'b0;
        md_done_int  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (md_start) begin
                    md_hold      = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = md_is_div ? DIV_LOAD : MUL_LOAD;
                    state_d      = MD_WAIT;
                end
            end
            MD_WAIT: begin
                // md_start is ignored here: the instruction occupying EX keeps
                // it high until it leaves, so it would otherwise re-trigger.
                if (!cnt_zero) begin
                    md_hold = 1'b1;
                    cnt_dec = 1'b1;
                end else begin
                    md_done_int = 1'b1;
                    state_d     = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign md_busy = (state_q == MD_WAIT);
    assign md_done = md_done_int;

    // ---------------------------------------------------------------------
    // Priority merge of stall/flush requests, highest first. A lower request
    // is fully masked whenever a higher one is active.
    // ---------------------------------------------------------------------
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (dmem_busy) begin
            // Freeze everything up to EX/MEM; MEM/WB receives a bubble.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (md_hold) begin
            // EX is occupied; exmem_en stays 1 so the bubble is loaded.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
        end else if (hz_stall) begin
            // A pending branch stays in ID and is re-evaluated next cycle.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (br_taken || jump) begin
            ifid_flush = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ---------------------------------------------------------------------
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // NOTE: only the small control state is reset; this block has no memory
    // arrays, which would be left unreset to keep them as plain RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Self-checking bench for pipe_stall_ctrl (MUL_LAT = 4, DIV_LAT = 32).
// The reference model tracks a mult/div operation as a pair of cycle stamps
// (issue cycle, completion cycle) and derives the stage controls from the
// request priority rules directly.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    localparam int MUL_LAT  = 4;
    localparam int DIV_LAT  = 32;
    localparam int PERF_MAX = 65535;

    logic        clk;
    logic        rst_n;
    logic        hz_stall;
    logic        br_taken;
    logic        jump;
    logic        md_start;
    logic        md_is_div;
    logic        dmem_busy;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_flush;
    logic        exmem_en;
    logic        exmem_flush;
    logic        memwb_flush;
    logic        md_busy;
    logic        md_done;
    logic [15:0] stall_cycles;

    pipe_stall_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (6),
        .PERF_W  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hz_stall     (hz_stall),
        .br_taken     (br_taken),
        .jump         (jump),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .dmem_busy    (dmem_busy),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .exmem_flush  (exmem_flush),
        .memwb_flush  (memwb_flush),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control bundle:
    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
    //  memwb_flush, md_busy, md_done}
    logic [9:0] obs;
    assign obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                  exmem_en, exmem_flush, memwb_flush, md_busy, md_done};

    int checks;
    int failures;

    // Reference model state
    int   cyc;
    int   op_start;
    int   op_end;
    int   perf;
    logic [9:0] exp_vec;
    int   exp_perf;
    logic e_pc;

    // Drive one cycle's inputs at the falling edge and compute expectations.
    task automatic drive(input logic rst, input logic hz, input logic br,
                         input logic jp, input logic ms, input logic dv,
                         input logic dm);
        logic active, hold, done, busy;
        logic e_ifid, e_ifidf, e_idex, e_idexf, e_exm, e_exmf, e_mwbf;
        @(negedge clk);
        rst_n     = rst;
        hz_stall  = hz;
        br_taken  = br;
        jump      = jp;
        md_start  = ms;
        md_is_div = dv;
        dmem_busy = dm;
        #1;
        if (!rst) begin
            op_start = -1;
            op_end   = -1;
            perf     = 0;
        end
        active = (cyc >= op_start) && (cyc <= op_end);
        if (rst && !active && ms) begin
            op_start = cyc;
            op_end   = cyc + (dv ? DIV_LAT : MUL_LAT);
            active   = 1'b1;
        end
        hold = rst && active && (cyc < op_end);
        done = rst && active && (cyc == op_end);
        busy = rst && active && (cyc > op_start);
        {e_pc, e_ifid, e_idex, e_exm} = 4'b1111;
        {e_ifidf, e_idexf, e_exmf, e_mwbf} = 4'b0000;
        if (!rst) begin
            {e_pc, e_ifid, e_idex, e_exm} = 4'b0000;
            {e_ifidf, e_idexf, e_exmf, e_mwbf} = 4'b1111;
        end else if (dm) begin
            {e_pc, e_ifid, e_idex, e_exm} = 4'b0000;
            e_mwbf = 1'b1;
        end else if (hold) begin
            {e_pc, e_ifid, e_idex} = 3'b000;
            e_exmf = 1'b1;
        end else if (hz) begin
            {e_pc, e_ifid} = 2'b00;
            e_idexf = 1'b1;
        end else if (br || jp) begin
            e_ifidf = 1'b1;
        end
        exp_vec  = {e_pc, e_ifid, e_ifidf, e_idex, e_idexf,
                    e_exm, e_exmf, e_mwbf, busy, done};
        exp_perf = perf;
    endtask

    // Let the rising edge happen and update the model.
    task automatic advance();
        @(posedge clk);
        if (rst_n && !e_pc && perf < PERF_MAX) perf = perf + 1;
        cyc = cyc + 1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs !== 10'b00_1_0_1_0_1_1_0_0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, obs, 10'b0010101100);
            end
            checks++;
            if (stall_cycles !== 16'd0) begin
                failures++;
                $display("FAIL reset_perf cyc=%0d got=%0d exp=0", cyc, stall_cycles);
            end
            advance();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== 10'b11_0_1_0_1_0_0_0_0 || obs !== exp_vec) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", obs, exp_vec);
        end
        checks++;
        if (stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL reset_release_perf got=%0d exp=0", stall_cycles);
        end
        advance();
    endtask

    task automatic test_divide();
        int base;
        base = exp_perf;
        for (int k = 0; k <= DIV_LAT; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, (k < DIV_LAT), 1'b1, 1'b0);
            checks++;
            if (obs !== exp_vec || stall_cycles !== 16'(exp_perf)) begin
                failures++;
                $display("FAIL divide_model k=%0d got=%b/%0d exp=%b/%0d",
                         k, obs, stall_cycles, exp_vec, exp_perf);
            end
            checks++;
            if (k < DIV_LAT && !(pc_en === 1'b0 && exmem_flush === 1'b1 && md_done === 1'b0)) begin
                failures++;
                $display("FAIL divide_hold k=%0d got pc_en=%b exmem_flush=%b md_done=%b exp 0/1/0",
                         k, pc_en, exmem_flush, md_done);
            end else if (k == DIV_LAT && !(md_done === 1'b1 && pc_en === 1'b1)) begin
                failures++;
                $display("FAIL divide_done got md_done=%b pc_en=%b exp 1/1", md_done, pc_en);
            end
            advance();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (int'(stall_cycles) !== base + DIV_LAT || md_done !== 1'b0) begin
            failures++;
            $display("FAIL divide_perf got=%0d/%b exp=%0d/0", stall_cycles, md_done, base + DIV_LAT);
        end
        advance();
    endtask

    task automatic test_hz_branch();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (!(idex_flush === 1'b1 && ifid_flush === 1'b0 && pc_en === 1'b0) || obs !== exp_vec) begin
            failures++;
            $display("FAIL hz_over_branch got=%b exp=%b", obs, exp_vec);
        end
        advance();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (!(ifid_flush === 1'b1 && pc_en === 1'b1) || obs !== exp_vec) begin
            failures++;
            $display("FAIL branch_after_hz got=%b exp=%b", obs, exp_vec);
        end
        advance();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ifid_flush !== 1'b1 || obs !== exp_vec) begin
            failures++;
            $display("FAIL jump_flush got=%b exp=%b", obs, exp_vec);
        end
        advance();
    endtask

    task automatic test_dmem_mul();
        for (int k = 0; k <= 7; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, (k <= MUL_LAT), 1'b0, (k >= 1 && k <= 6));
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL dmem_mul_model k=%0d got=%b exp=%b", k, obs, exp_vec);
            end
            checks++;
            if (k >= 1 && k <= 6 && !(exmem_en === 1'b0 && memwb_flush === 1'b1)) begin
                failures++;
                $display("FAIL dmem_mul_freeze k=%0d got exmem_en=%b memwb_flush=%b exp 0/1",
                         k, exmem_en, memwb_flush);
            end else if ((md_done === 1'b1) !== (k == MUL_LAT)) begin
                failures++;
                $display("FAIL dmem_mul_done k=%0d got=%b exp=%b", k, md_done, (k == MUL_LAT));
            end else if (k >= 5 && md_busy !== 1'b0) begin
                failures++;
                $display("FAIL dmem_mul_run k=%0d got md_busy=%b exp=0", k, md_busy);
            end else if (k == 7 && {pc_en, ifid_en, idex_en, exmem_en, memwb_flush} !== 5'b11110) begin
                failures++;
                $display("FAIL dmem_mul_release got=%b exp=11110",
                         {pc_en, ifid_en, idex_en, exmem_en, memwb_flush});
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        ndone = 0;
        for (int k = 0; k < 2 * MUL_LAT + 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, (k < 2 * MUL_LAT + 1), 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL back_to_back k=%0d got=%b exp=%b", k, obs, exp_vec);
            end
            if (md_done === 1'b1) ndone++;
            checks++;
            if (k == 2 * MUL_LAT + 1 && ndone != 2) begin
                failures++;
                $display("FAIL back_to_back_count got=%0d exp=2", ndone);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 44; k++) begin
            drive(!(k == 10 || k == 11), 1'b0, 1'b0, 1'b0, (k < 10), 1'b1, 1'b0);
            checks++;
            if (obs !== exp_vec || stall_cycles !== 16'(exp_perf)) begin
                failures++;
                $display("FAIL reset_mid_model k=%0d got=%b/%0d exp=%b/%0d",
                         k, obs, stall_cycles, exp_vec, exp_perf);
            end
            checks++;
            if (k >= 10 && (md_done !== 1'b0 || md_busy !== 1'b0)) begin
                failures++;
                $display("FAIL reset_mid_abandon k=%0d got done=%b busy=%b exp 0/0", k, md_done, md_busy);
            end else if (k >= 12 && pc_en !== 1'b1) begin
                failures++;
                $display("FAIL reset_mid_run k=%0d got pc_en=%b exp=1", k, pc_en);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic r, h, b, j, m, d, dm;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(199) != 0);
            h  = ($urandom_range(3) == 0);
            b  = ($urandom_range(3) == 0);
            j  = ($urandom_range(5) == 0);
            m  = ($urandom_range(7) == 0);
            d  = ($urandom_range(3) == 0);
            dm = ($urandom_range(4) == 0);
            drive(r, h, b, j, m, d, dm);
            checks++;
            if (obs !== exp_vec || stall_cycles !== 16'(exp_perf)) begin
                failures++;
                $display("FAIL random i=%0d got=%b/%0d exp=%b/%0d",
                         i, obs, stall_cycles, exp_vec, exp_perf);
            end
            advance();
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 65536 + 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (stall_cycles !== 16'hFFFF || exp_perf != PERF_MAX) begin
                failures++;
                $display("FAIL saturation k=%0d got=%h exp=ffff", k, stall_cycles);
            end
            advance();
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        op_start  = -1;
        op_end    = -1;
        perf      = 0;
        e_pc      = 1'b1;
        rst_n     = 1'b0;
        hz_stall  = 1'b0;
        br_taken  = 1'b0;
        jump      = 1'b0;
        md_start  = 1'b0;
        md_is_div = 1'b0;
        dmem_busy = 1'b0;
        test_reset();
        test_divide();
        test_hz_branch();
        test_dmem_mul();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
